or_n_bit: RTL and testbench

Registered N-bit bitwise-OR unit with condition flags, one of the ALU's logic-operation slices. It computes `in_a | in_b` and reports N/Z/V/C flags in the packed order the ALU flag mux expects. Results and flags are registered with one-cycle latency and a valid qualifier, so the slice drops into the ALU's pipelined datapath.

---
 rtl/or_n_bit.sv | 57 +++++
 tb/tb_or_n_bit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/or_n_bit.sv
// Registered N-bit bitwise OR slice with {N,Z,V,C} flags and one-cycle latency.
// Optional sticky N/Z accumulator is enabled by defining OR_N_BIT_STICKY_EN.
module or_n_bit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    output logic [N-1:0] out,
    output logic [3:0]   flags_n_z_v_c
`ifdef OR_N_BIT_STICKY_EN
    ,
    input  logic         sticky_clr,
    output logic [1:0]   sticky_n_z
`endif
);

    logic [N-1:0] res;
    logic         flag_n;
    logic         flag_z;

    assign res    = in_a | in_b;
    assign flag_n = res[N-1];
    assign flag_z = (res == '0);

    // Result and flags only load on valid operands, so idle-cycle X/Z never reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out           <= '0;
            flags_n_z_v_c <= 4'b0000;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out           <= res;
                flags_n_z_v_c <= {flag_n, flag_z, 2'b00};
            end
        end
    end

`ifdef OR_N_BIT_STICKY_EN
    // Clear wins over accumulation; the operation in a clearing cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_n_z <= 2'b00;
        end else if (sticky_clr) begin
            sticky_n_z <= 2'b00;
        end else if (in_valid) begin
            sticky_n_z <= sticky_n_z | {flag_n, flag_z};
        end
    end
`endif

endmodule

// File: tb/tb_or_n_bit.sv
// Bench for or_n_bit: four widths (8, 1, 16, 64) driven in lockstep and compared
// against an arithmetic reference model of the OR slice.
module tb_or_n_bit;

    logic clk;
    logic rst_n;
    logic in_valid;

    logic [7:0]  a8,  b8,  o8;
    logic [0:0]  a1,  b1,  o1;
    logic [15:0] a16, b16, o16;
    logic [63:0] a64, b64, o64;
    logic [3:0]  f8, f1, f16, f64;
    logic        v8, v1, v16, v64;
    logic        sticky_clr;
`ifdef OR_N_BIT_STICKY_EN
    logic [1:0]  sticky8;
`endif

    int tests = 0;
    int fails = 0;

    int          widths [4] = '{8, 1, 16, 64};
    logic [63:0] exp_out   [4];
    logic [3:0]  exp_flags [4];
    logic        exp_valid [4];
    logic [1:0]  exp_sticky;

    or_n_bit #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(a8), .in_b(b8),
        .out_valid(v8), .out(o8), .flags_n_z_v_c(f8)
`ifdef OR_N_BIT_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_n_z(sticky8)
`endif
    );
    or_n_bit #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(a1), .in_b(b1),
        .out_valid(v1), .out(o1), .flags_n_z_v_c(f1)
`ifdef OR_N_BIT_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_n_z()
`endif
    );
    or_n_bit #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(a16), .in_b(b16),
        .out_valid(v16), .out(o16), .flags_n_z_v_c(f16)
`ifdef OR_N_BIT_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_n_z()
`endif
    );
    or_n_bit #(.N(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(a64), .in_b(b64),
        .out_valid(v64), .out(o64), .flags_n_z_v_c(f64)
`ifdef OR_N_BIT_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_n_z()
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] width_mask(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s out w8", tag),    {56'd0, o8},  exp_out[0]);
        check($sformatf("%s flags w8", tag),  {60'd0, f8},  {60'd0, exp_flags[0]});
        check($sformatf("%s valid w8", tag),  {63'd0, v8},  {63'd0, exp_valid[0]});
        check($sformatf("%s out w1", tag),    {63'd0, o1},  exp_out[1]);
        check($sformatf("%s flags w1", tag),  {60'd0, f1},  {60'd0, exp_flags[1]});
        check($sformatf("%s valid w1", tag),  {63'd0, v1},  {63'd0, exp_valid[1]});
        check($sformatf("%s out w16", tag),   {48'd0, o16}, exp_out[2]);
        check($sformatf("%s flags w16", tag), {60'd0, f16}, {60'd0, exp_flags[2]});
        check($sformatf("%s valid w16", tag), {63'd0, v16}, {63'd0, exp_valid[2]});
        check($sformatf("%s out w64", tag),   o64,          exp_out[3]);
        check($sformatf("%s flags w64", tag), {60'd0, f64}, {60'd0, exp_flags[3]});
        check($sformatf("%s valid w64", tag), {63'd0, v64}, {63'd0, exp_valid[3]});
`ifdef OR_N_BIT_STICKY_EN
        check($sformatf("%s sticky", tag), {62'd0, sticky8}, {62'd0, exp_sticky});
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_out[i]   = '0;
            exp_flags[i] = 4'b0000;
            exp_valid[i] = 1'b0;
        end
        exp_sticky = 2'b00;
    endtask

    // One clock: drive operands, advance past the edge, update model, compare.
    task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic clr);
        logic [63:0] av [4];
        logic [63:0] bv [4];
        logic [63:0] res;
        logic        n_flag;
        logic        z_flag;
        av[0] = {56'd0, a};
        bv[0] = {56'd0, b};
        for (int i = 1; i < 4; i++) begin
            av[i] = {$urandom, $urandom} & width_mask(widths[i]);
            bv[i] = {$urandom, $urandom} & width_mask(widths[i]);
        end
        in_valid   = v;
        sticky_clr = clr;
        a8 = a;
        b8 = b;
        if (v) begin
            a1 = av[1][0:0];  b1 = bv[1][0:0];
            a16 = av[2][15:0]; b16 = bv[2][15:0];
            a64 = av[3];       b64 = bv[3];
        end else begin
            a1 = 'x;  b1 = 'x;
            a16 = 'x; b16 = 'x;
            a64 = 'x; b64 = 'x;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_valid[i] = v;
            if (v) begin
                res    = av[i] | bv[i];
                n_flag = (res >= (64'd1 << (widths[i] - 1)));
                z_flag = (res == 64'd0);
                exp_out[i]   = res;
                exp_flags[i] = {n_flag, z_flag, 1'b0, 1'b0};
                if (i == 0 && !clr) exp_sticky = exp_sticky | {n_flag, z_flag};
            end
        end
        if (clr) exp_sticky = 2'b00;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        a16 = '0; b16 = '0; a64 = '0; b64 = '0;

        // Load non-zero results, then assert reset mid-cycle with no edge in between.
        in_valid = 1'b1;
        a8 = 8'hFF; a1 = 1'b1; a16 = 16'hFFFF; a64 = {64{1'b1}};
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");

        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            sticky_clr = 1'($urandom);
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        rst_n = 1'b1;

        step("dir_0_0",   1'b1, 8'd0,   8'd0,   1'b0);
        step("dir_1_0",   1'b1, 8'd1,   8'd0,   1'b0);
        step("dir_1_1",   1'b1, 8'd1,   8'd1,   1'b0);
        step("dir_3_4",   1'b1, 8'd3,   8'd4,   1'b0);
        step("dir_15_15", 1'b1, 8'd15,  8'd15,  1'b0);
        step("sign_80_01", 1'b1, 8'h80, 8'h01,  1'b0);
        step("sign_ff_00", 1'b1, 8'hFF, 8'h00,  1'b0);
        step("hold_load", 1'b1, 8'd3,   8'd4,   1'b0);
        step("hold_idle", 1'b0, 8'hAA,  8'hXX,  1'b0);
        step("hold_idle2", 1'b0, 8'hXX, 8'hXX,  1'b0);

        // Sticky sequence: clear, accumulate Z then N, then clear alongside a valid op.
        step("sticky_clr0", 1'b0, 8'h00, 8'h00, 1'b1);
        step("sticky_z",    1'b1, 8'h00, 8'h00, 1'b0);
        step("sticky_n",    1'b1, 8'h80, 8'h00, 1'b0);
        step("sticky_clr1", 1'b1, 8'h01, 8'h00, 1'b1);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                ra = 8'h00;
                rb = 8'h00;
            end
            step($sformatf("rand%0d", k), 1'($urandom_range(0, 3) != 0), ra, rb,
                 1'($urandom_range(0, 7) == 0));
        end

        // Reset mid-stream discards the in-flight result; next valid edge captures normally.
        in_valid = 1'b1;
        a8 = 8'h5A;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_midstream");
        @(posedge clk);
        #1;
        check_all("reset_midstream_edge");
        rst_n = 1'b1;
        step("post_reset", 1'b1, 8'h12, 8'h40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
